// File: rtl/cache_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arb_pkg
//  Description : Shared types and constants for the cache/memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Grant encoding stored alongside the request register
  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  // Default bus widths
  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/cache_arb_prio.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arb_prio
//  Description : Winner select between data and instruction caches. Data is
//                preferred, but after MAX_DATA_RUN consecutive data grants
//                with an instruction request waiting, instruction wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_arb_prio
  import cache_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_idle,
  input  logic inst_req,
  input  logic data_req,
  output logic winner
);

  // Run limit is at most 15, so four bits always suffice
  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  logic [3:0] run_cnt;
  logic       starve;
  logic       grant;

  assign starve = inst_req && (run_cnt == RUN_MAX);
  assign grant  = in_idle && (inst_req || data_req);

  // Data wins unless the instruction side has waited out its run budget
  always_comb begin
    winner = GNT_INST;
    if (data_req && !starve) begin
      winner = GNT_DATA;
    end
  end

  // Count data grants made while instruction fetch is waiting; saturate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt <= 4'd0;
    end else if (grant && (winner == GNT_INST)) begin
      run_cnt <= 4'd0;
    end else if (grant && inst_req) begin
      if (run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + 4'd1;
      end
    end else if (in_idle && !inst_req) begin
      run_cnt <= 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_arbiter
//  Description : Grants the SRAM-like memory bus to the instruction or data
//                cache, runs the address/data handshake from a registered
//                copy of the winning request and returns a one-cycle done
//                pulse with read data to the grantee.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4,
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DATA_W       = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_cache_req,
  input  logic [ADDR_W-1:0] inst_cache_addr,
  output logic [DATA_W-1:0] inst_cache_rdata,
  output logic              inst_cache_dok,
  input  logic              data_cache_req,
  input  logic [3:0]        data_cache_wen,
  input  logic [ADDR_W-1:0] data_cache_addr,
  input  logic [DATA_W-1:0] data_cache_wdata,
  output logic [DATA_W-1:0] data_cache_rdata,
  output logic              data_cache_dok,
  output logic              mem_req,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state;
  arb_state_t        next_state;
  logic              latch;
  logic              complete;
  logic              winner;
  logic              gnt_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [3:0]        req_wen_q;
  logic [DATA_W-1:0] req_wdata_q;

  cache_arb_prio #(
    .MAX_DATA_RUN (MAX_DATA_RUN)
  ) u_prio (
    .clk      (clk),
    .reset    (reset),
    .in_idle  (state == IDLE),
    .inst_req (inst_cache_req),
    .data_req (data_cache_req),
    .winner   (winner)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; bus handshakes outside their state are ignored
  always_comb begin
    next_state = state;
    latch      = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (inst_cache_req || data_cache_req) begin
          latch      = 1'b1;
          next_state = ADDR;
        end
      end
      ADDR: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            complete   = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (mem_data_ok) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture the winning request; it stays frozen until the next grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q       <= GNT_INST;
      req_addr_q  <= '0;
      req_wen_q   <= 4'd0;
      req_wdata_q <= '0;
    end else if (latch) begin
      gnt_q <= winner;
      if (winner == GNT_DATA) begin
        req_addr_q  <= data_cache_addr;
        req_wen_q   <= data_cache_wen;
        req_wdata_q <= data_cache_wdata;
      end else begin
        req_addr_q  <= inst_cache_addr;
        req_wen_q   <= 4'd0;
        req_wdata_q <= '0;
      end
    end
  end

  // Bus request is its own flop so no cache input reaches the bus directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_q <= 1'b0;
    end else begin
      mem_req_q <= (next_state == ADDR);
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = req_addr_q;
  assign mem_wen   = req_wen_q;
  assign mem_wdata = req_wdata_q;

  assign inst_cache_dok   = complete && (gnt_q == GNT_INST);
  assign data_cache_dok   = complete && (gnt_q == GNT_DATA);
  assign inst_cache_rdata = mem_rdata;
  assign data_cache_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_mem_arbiter
//  Description : Self-checking bench for cache_mem_arbiter with a scoreboard
//                of expected grants and a programmable-latency memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_cache_req;
  logic [31:0] inst_cache_addr;
  logic [31:0] inst_cache_rdata;
  logic        inst_cache_dok;
  logic        data_cache_req;
  logic [3:0]  data_cache_wen;
  logic [31:0] data_cache_addr;
  logic [31:0] data_cache_wdata;
  logic [31:0] data_cache_rdata;
  logic        data_cache_dok;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  cache_mem_arbiter #(
    .MAX_DATA_RUN (4),
    .ADDR_W       (32),
    .DATA_W       (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .inst_cache_req   (inst_cache_req),
    .inst_cache_addr  (inst_cache_addr),
    .inst_cache_rdata (inst_cache_rdata),
    .inst_cache_dok   (inst_cache_dok),
    .data_cache_req   (data_cache_req),
    .data_cache_wen   (data_cache_wen),
    .data_cache_addr  (data_cache_addr),
    .data_cache_wdata (data_cache_wdata),
    .data_cache_rdata (data_cache_rdata),
    .data_cache_dok   (data_cache_dok),
    .mem_req          (mem_req),
    .mem_wen          (mem_wen),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_addr_ok      (mem_addr_ok),
    .mem_data_ok      (mem_data_ok),
    .mem_rdata        (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;     // 1 = data cache, 0 = instruction cache
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // memory model
  int          addr_dly = 0;
  int          data_dly = 0;
  int          a_wait   = 0;
  int          d_wait   = 0;
  bit          pending  = 0;
  bit          spur     = 0;
  logic [31:0] acc_addr;
  logic [3:0]  acc_wen;
  logic [31:0] acc_wdata;

  // requester model
  int          i_left = 0;
  int          d_left = 0;
  logic [31:0] i_addr_v  = 32'h0;
  logic [31:0] d_addr_v  = 32'h0;
  logic [3:0]  d_wen_v   = 4'h0;
  logic [31:0] d_wdata_v = 32'h0;
  bit          mutate    = 0;

  // per-test observation
  int          req_cycles   = 0;
  int          dok_count    = 0;
  int          last_dok_cyc = 0;
  bit          track_stable = 0;
  bit          unstable     = 0;
  logic [31:0] st_addr;
  logic [3:0]  st_wen;
  logic [31:0] st_wdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic push_exp(input logic gnt, input logic [31:0] addr,
                          input logic [3:0] wen, input logic [31:0] wdata);
    exp_t e;
    e.gnt   = gnt;
    e.addr  = addr;
    e.wen   = wen;
    e.wdata = wdata;
    e.rdata = mem_val(addr);
    sb.push_back(e);
  endtask

  // One clock: drive requesters and memory, then observe the completion
  task automatic step();
    bit   issued;
    logic dok_any;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    inst_cache_req   = (i_left > 0);
    inst_cache_addr  = i_addr_v;
    data_cache_req   = (d_left > 0);
    data_cache_addr  = d_addr_v;
    data_cache_wen   = d_wen_v;
    data_cache_wdata = d_wdata_v;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'hBAD0_0000 | 32'(cyc);
    issued      = 0;
    if (mem_req) begin
      req_cycles++;
      if (track_stable && (mem_addr !== st_addr || mem_wen !== st_wen || mem_wdata !== st_wdata))
        unstable = 1;
      if (a_wait < addr_dly) begin
        a_wait++;
      end else begin
        a_wait      = 0;
        mem_addr_ok = 1'b1;
        acc_addr    = mem_addr;
        acc_wen     = mem_wen;
        acc_wdata   = mem_wdata;
        if (data_dly == 0) begin
          mem_data_ok = 1'b1;
          mem_rdata   = mem_val(mem_addr);
          issued      = 1;
        end else begin
          pending = 1;
          d_wait  = 0;
        end
      end
      if (mutate) d_addr_v = 32'h0000_2000;
    end else if (pending) begin
      d_wait++;
      if (d_wait >= data_dly) begin
        mem_data_ok = 1'b1;
        mem_rdata   = mem_val(acc_addr);
        pending     = 0;
        issued      = 1;
      end
    end
    if (spur) begin
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
    end
    #1;
    dok_any = inst_cache_dok | data_cache_dok;
    if (spur) begin
      check_eq("spurious_no_dok", {63'd0, dok_any}, 64'd0);
    end else if (issued || dok_any) begin
      check_eq("dok_on_data_ok", {63'd0, dok_any}, 64'd1);
      if (dok_any) begin
        dok_count++;
        last_dok_cyc = cyc;
        check_eq("dok_exclusive", {63'd0, inst_cache_dok & data_cache_dok}, 64'd0);
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_dok", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("grant_order", {63'd0, data_cache_dok}, {63'd0, e.gnt});
          check_eq("bus_addr", {32'd0, acc_addr}, {32'd0, e.addr});
          check_eq("bus_wen", {60'd0, acc_wen}, {60'd0, e.wen});
          if (e.wen != 4'd0)
            check_eq("bus_wdata", {32'd0, acc_wdata}, {32'd0, e.wdata});
          check_eq("rdata", {32'd0, (e.gnt ? data_cache_rdata : inst_cache_rdata)},
                   {32'd0, e.rdata});
        end
        if (data_cache_dok && d_left > 0) d_left--;
        if (inst_cache_dok && i_left > 0) i_left--;
      end
    end
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || i_left != 0 || d_left != 0) && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_done_in_budget"}, {63'd0, (n < budget)}, 64'd1);
    step();
  endtask

  task automatic clear_obs();
    req_cycles = 0;
    dok_count  = 0;
    unstable   = 0;
  endtask

  int c0;

  initial begin
    reset            = 1'b1;
    inst_cache_req   = 1'b0;
    inst_cache_addr  = 32'h0;
    data_cache_req   = 1'b0;
    data_cache_wen   = 4'h0;
    data_cache_addr  = 32'h0;
    data_cache_wdata = 32'h0;
    mem_addr_ok      = 1'b0;
    mem_data_ok      = 1'b0;
    mem_rdata        = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check_eq("rst_mem_wen", {60'd0, mem_wen}, 64'd0);
    check_eq("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check_eq("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    check_eq("rst_dok", {62'd0, inst_cache_dok, data_cache_dok}, 64'd0);
    reset = 1'b0;
    step();

    // Zero-wait data read of 0x1000
    clear_obs();
    addr_dly = 0; data_dly = 0;
    d_addr_v = 32'h0000_1000; d_wen_v = 4'h0; d_wdata_v = 32'h0; d_left = 1;
    push_exp(1'b1, 32'h0000_1000, 4'h0, 32'h0);
    c0 = cyc + 1;
    run_until_done("t1", 50);
    check_eq("t1_latency", 64'(last_dok_cyc), 64'(c0 + 1));
    check_eq("t1_req_cycles", 64'(req_cycles), 64'd1);

    // Write with delayed address and data acknowledge
    clear_obs();
    addr_dly = 3; data_dly = 2;
    d_addr_v = 32'h0000_3000; d_wen_v = 4'b0011; d_wdata_v = 32'h1234_5678; d_left = 1;
    st_addr = 32'h0000_3000; st_wen = 4'b0011; st_wdata = 32'h1234_5678; track_stable = 1;
    push_exp(1'b1, 32'h0000_3000, 4'b0011, 32'h1234_5678);
    c0 = cyc + 1;
    run_until_done("t2", 50);
    track_stable = 0;
    check_eq("t2_req_cycles", 64'(req_cycles), 64'd4);
    check_eq("t2_dok_once", 64'(dok_count), 64'd1);
    check_eq("t2_fields_stable", {63'd0, unstable}, 64'd0);
    check_eq("t2_latency", 64'(last_dok_cyc), 64'(c0 + 6));

    // Both caches requesting continuously
    clear_obs();
    addr_dly = 0; data_dly = 1;
    i_addr_v = 32'h0000_0100;
    d_addr_v = 32'h0000_0200; d_wen_v = 4'h0; d_wdata_v = 32'h0;
    i_left = 2; d_left = 8;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push_exp(1'b0, 32'h0000_0100, 4'h0, 32'h0);
      else                  push_exp(1'b1, 32'h0000_0200, 4'h0, 32'h0);
    end
    run_until_done("t3", 300);
    check_eq("t3_dok_count", 64'(dok_count), 64'd10);

    // Address changed by requester after grant
    clear_obs();
    addr_dly = 2; data_dly = 1;
    d_addr_v = 32'h0000_1000; d_wen_v = 4'h0; d_left = 1;
    st_addr = 32'h0000_1000; st_wen = 4'h0; st_wdata = 32'h0; track_stable = 1;
    mutate = 1;
    push_exp(1'b1, 32'h0000_1000, 4'h0, 32'h0);
    run_until_done("t4", 50);
    mutate = 0; track_stable = 0;
    check_eq("t4_addr_held", {63'd0, unstable}, 64'd0);

    // Reset while waiting for data
    clear_obs();
    addr_dly = 0; data_dly = 5;
    d_addr_v = 32'h0000_4000; d_wen_v = 4'h0; d_left = 1;
    push_exp(1'b1, 32'h0000_4000, 4'h0, 32'h0);
    step();
    step();
    step();
    check_eq("t5_in_data_no_req", {63'd0, mem_req}, 64'd0);
    reset = 1'b1;
    d_left = 0;
    data_cache_req = 1'b0;
    pending = 0;
    sb.delete();
    #1;
    check_eq("t5_rst_mem_req", {63'd0, mem_req}, 64'd0);
    check_eq("t5_rst_no_dok", {62'd0, inst_cache_dok, data_cache_dok}, 64'd0);
    step();
    reset = 1'b0;
    spur = 1;
    step();
    step();
    spur = 0;
    step();
    check_eq("t5_idle_after_spur", {63'd0, mem_req}, 64'd0);
    check_eq("t5_no_dok_total", 64'(dok_count), 64'd0);

    // Normal operation after reset and spurious handshakes
    clear_obs();
    addr_dly = 1; data_dly = 0;
    i_addr_v = 32'h0000_0500; i_left = 1;
    push_exp(1'b0, 32'h0000_0500, 4'h0, 32'h0);
    run_until_done("t6", 50);
    check_eq("t6_dok_count", 64'(dok_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
